// File: rtl/parking_lot_ctrl.sv
// parking_lot_ctrl: gate-sensor FSM with a saturating occupancy count. Results land 1 edge after the final ab==00 (3 with PARK_SYNC_EN).
// There is no backpressure: ab is consumed every cycle, and malformed sequences park in WAIT until ab==00.
module parking_lot_ctrl #(
  parameter int CAPACITY = 25,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             clear,
  output logic             enter_pulse,
  output logic             exit_pulse,
  output logic             reject
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT} state_t;

  state_t           state;
  logic [1:0]       ab;
  logic             rst_meta, rst_q;
  logic             ent_done, ext_done, can_inc, can_dec;
  logic [CNT_W-1:0] cnt_inc, cnt_dec;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta <= 1'b0;
      rst_q    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_q    <= rst_meta;
    end
  end

`ifdef PARK_SYNC_EN
  logic [1:0] ab_meta, ab_sync;
  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) begin
      ab_meta <= 2'b00;
      ab_sync <= 2'b00;
    end else begin
      ab_meta <= {a, b};
      ab_sync <= ab_meta;
    end
  end
  assign ab = ab_sync;
`else
  assign ab = {a, b};
`endif

  always_comb begin
    ent_done = (state == EN3) && (ab == 2'b00);
    ext_done = (state == EX3) && (ab == 2'b00);
    can_inc  = (count != CAP);
    can_dec  = (count != '0);
    cnt_inc  = count + CNT_W'(1);
    cnt_dec  = count - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) begin
      state       <= IDLE;
      count       <= '0;
      full        <= 1'b0;
      clear       <= 1'b1;
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      reject      <= 1'b0;
    end else begin
      enter_pulse <= ent_done && can_inc;
      exit_pulse  <= ext_done && can_dec;
      reject      <= (ent_done && !can_inc) || (ext_done && !can_dec);
      // full/clear are computed from the next count so they never lag it.
      if (ent_done && can_inc) begin
        count <= cnt_inc;
        full  <= (cnt_inc == CAP);
        clear <= 1'b0;
      end else if (ext_done && can_dec) begin
        count <= cnt_dec;
        full  <= 1'b0;
        clear <= (cnt_dec == '0);
      end

      case (state)
        IDLE: case (ab)
          2'b10:   state <= EN1;
          2'b01:   state <= EX1;
          2'b11:   state <= WAIT;
          default: state <= IDLE;
        endcase
        EN1: case (ab)
          2'b11:   state <= EN2;
          2'b00:   state <= IDLE;
          2'b01:   state <= WAIT;
          default: state <= EN1;
        endcase
        EN2: case (ab)
          2'b01:   state <= EN3;
          2'b10:   state <= EN1;
          2'b00:   state <= WAIT;
          default: state <= EN2;
        endcase
        EN3: case (ab)
          2'b00:   state <= IDLE;
          2'b11:   state <= EN2;
          2'b10:   state <= WAIT;
          default: state <= EN3;
        endcase
        EX1: case (ab)
          2'b11:   state <= EX2;
          2'b00:   state <= IDLE;
          2'b10:   state <= WAIT;
          default: state <= EX1;
        endcase
        EX2: case (ab)
          2'b10:   state <= EX3;
          2'b01:   state <= EX1;
          2'b00:   state <= WAIT;
          default: state <= EX2;
        endcase
        EX3: case (ab)
          2'b00:   state <= IDLE;
          2'b11:   state <= EX2;
          2'b01:   state <= WAIT;
          default: state <= EX3;
        endcase
        default: state <= (ab == 2'b00) ? IDLE : WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl; latency L follows PARK_SYNC_EN.
module tb_parking_lot_ctrl;

  localparam int CAP = 25;
`ifdef PARK_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [4:0] count;
  logic       full, clear, enter_pulse, exit_pulse, reject;

  int checks = 0;
  int failures = 0;
  int mc = 0;

  parking_lot_ctrl #(.CAPACITY(CAP), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b),
    .count(count), .full(full), .clear(clear),
    .enter_pulse(enter_pulse), .exit_pulse(exit_pulse), .reject(reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stb();
    return {29'd0, enter_pulse, exit_pulse, reject};
  endfunction

  task automatic drive(input logic [1:0] v);
    @(negedge clk);
    {a, b} = v;
    repeat (4) @(negedge clk);
  endtask

  // Apply the final ab=00 and pin the result to exactly L edges later.
  task automatic finish_seq(input string tag, input logic en, input logic ex,
                            input logic rej, input int newc);
    int oldc;
    oldc = mc;
    @(negedge clk);
    chk({tag, "_pre_stb"}, stb(), 32'd0);
    {a, b} = 2'b00;
    repeat (L - 1) @(posedge clk);
    #1;
    chk({tag, "_early_cnt"}, 32'(count), 32'(oldc));
    @(posedge clk);
    #1;
    chk({tag, "_cnt"}, 32'(count), 32'(newc));
    chk({tag, "_stb"}, stb(), {29'd0, en, ex, rej});
    chk({tag, "_full"}, 32'(full), 32'(newc == CAP));
    chk({tag, "_clear"}, 32'(clear), 32'(newc == 0));
    @(posedge clk);
    #1;
    chk({tag, "_stb_after"}, stb(), 32'd0);
    mc = newc;
    repeat (2) @(negedge clk);
  endtask

  task automatic car_in();
    drive(2'b10); drive(2'b11); drive(2'b01);
    if (mc < CAP) finish_seq("entry", 1'b1, 1'b0, 1'b0, mc + 1);
    else          finish_seq("entry_full", 1'b0, 1'b0, 1'b1, mc);
  endtask

  task automatic car_out();
    drive(2'b01); drive(2'b11); drive(2'b10);
    if (mc > 0) finish_seq("exit", 1'b0, 1'b1, 1'b0, mc - 1);
    else        finish_seq("exit_empty", 1'b0, 1'b0, 1'b1, mc);
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(negedge clk);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_clear", 32'(clear), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_stb", stb(), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // T2: single entry
    car_in();

    // T3: abort on entry side and on exit side
    drive(2'b10); drive(2'b11); drive(2'b10);
    finish_seq("abort_en", 1'b0, 1'b0, 1'b0, mc);
    drive(2'b01); drive(2'b11); drive(2'b01);
    finish_seq("abort_ex", 1'b0, 1'b0, 1'b0, mc);

    // T6: 2-bit jump goes to WAIT, then next entry still counts
    drive(2'b10); drive(2'b01);
    finish_seq("glitch", 1'b0, 1'b0, 1'b0, mc);
    car_in();

    // T4: fill to capacity, overflow attempt, one exit
    while (mc < CAP) car_in();
    car_in();
    car_out();

    // T1: reset in the middle of EN2
    drive(2'b10); drive(2'b11);
    @(negedge clk);
    reset_n = 1'b0;
    {a, b} = 2'b00;
    #1;
    chk("mid_rst_cnt", 32'(count), 32'd0);
    chk("mid_rst_clear", 32'(clear), 32'd1);
    chk("mid_rst_full", 32'(full), 32'd0);
    mc = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // T5: exit while empty, then confirm the FSM restarted in IDLE
    car_out();
    car_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
